// File: rtl/led_arbiter.sv
// led_arbiter: three requesters share one 8-LED bank.
// While no one owns the bank it shows a slice of a free-running heartbeat
// counter. An owner keeps the bank for at least HOLD_CYCLES cycles. One
// all-dark-grant GAP cycle separates any two ownerships.
// Optional feature: define LED_ARB_RR_EN for round-robin arbitration.
// With it undefined, arbitration is fixed priority (req[0] highest).
// led is active-low: 0 = lit.
module led_arbiter #(
    parameter int HOLD_CYCLES = 1024,
    parameter int HB_BIT      = 23
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    output logic [2:0] grant,
    output logic [7:0] led,
    output logic       busy
);

    localparam logic [15:0] HOLD = 16'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hb_q, hb_d;
    logic [15:0] hold_q, hold_d;
    logic [1:0]  owner_q, owner_d;
    logic [2:0]  grant_q, grant_d;
    logic [7:0]  led_q, led_d;
    logic        busy_q, busy_d;

`ifdef LED_ARB_RR_EN
    logic [1:0]  last_owner_q, last_owner_d;
`endif

    logic [1:0]  win;
    logic        any_req;
    logic [7:0]  owner_data;
    logic [15:0] hold_inc;
    logic        expired;
    logic        owner_req;
    logic        other_req;

    // Only an 8-bit slice of the heartbeat reaches the LEDs.
    logic        unused_hb;
    assign unused_hb = ^hb_q;

    assign any_req = |req;

    // Pick the next owner from the current request vector.
    always_comb begin
        win = 2'd2;
`ifdef LED_ARB_RR_EN
        // Search upward from the requester after the previous owner.
        case (last_owner_q)
            2'd0: begin
                if (req[1])      win = 2'd1;
                else if (req[2]) win = 2'd2;
                else             win = 2'd0;
            end
            2'd1: begin
                if (req[2])      win = 2'd2;
                else if (req[0]) win = 2'd0;
                else             win = 2'd1;
            end
            default: begin
                if (req[0])      win = 2'd0;
                else if (req[1]) win = 2'd1;
                else             win = 2'd2;
            end
        endcase
`else
        if (req[0])      win = 2'd0;
        else if (req[1]) win = 2'd1;
        else             win = 2'd2;
`endif
    end

    // Owner-side views: its LED pattern, its request, and competing requests.
    always_comb begin
        owner_data = data2;
        case (owner_q)
            2'd0:    owner_data = data0;
            2'd1:    owner_data = data1;
            default: owner_data = data2;
        endcase
        // grant_q is one-hot on the owner throughout OWN.
        owner_req = |(req & grant_q);
        other_req = |(req & ~grant_q);
        // hold_q counts completed OWN cycles; the grant may end once the
        // current cycle brings it to HOLD, giving HOLD_CYCLES OWN cycles.
        hold_inc  = (hold_q == HOLD) ? hold_q : hold_q + 16'd1;
        expired   = (hold_inc == HOLD);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        hb_d    = hb_q + 32'd1;
        hold_d  = hold_q;
        owner_d = owner_q;
        grant_d = grant_q;
        led_d   = led_q;
`ifdef LED_ARB_RR_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            S_IDLE: begin
                grant_d = 3'b000;
                led_d   = ~hb_q[HB_BIT +: 8];
                if (any_req) begin
                    state_d = S_OWN;
                    owner_d = win;
                    grant_d = 3'b001 << win;
                    hold_d  = 16'd0;
`ifdef LED_ARB_RR_EN
                    last_owner_d = win;
`endif
                end
            end
            S_OWN: begin
                led_d  = ~owner_data;
                hold_d = hold_inc;
                // No preemption and no early release before the hold expires.
                if (expired && (!owner_req || other_req)) begin
                    state_d = S_GAP;
                    grant_d = 3'b000;
                end
            end
            S_GAP: begin
                // LEDs freeze for the single dark-grant cycle.
                grant_d = 3'b000;
                if (any_req) begin
                    state_d = S_OWN;
                    owner_d = win;
                    grant_d = 3'b001 << win;
                    hold_d  = 16'd0;
`ifdef LED_ARB_RR_EN
                    last_owner_d = win;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 3'b000;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            hb_q    <= 32'd0;
            hold_q  <= 16'd0;
            owner_q <= 2'd2;
            grant_q <= 3'b000;
            led_q   <= 8'hFF;
            busy_q  <= 1'b0;
`ifdef LED_ARB_RR_EN
            last_owner_q <= 2'd2;
`endif
        end else begin
            state_q <= state_d;
            hb_q    <= hb_d;
            hold_q  <= hold_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
`ifdef LED_ARB_RR_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    assign grant = grant_q;
    assign led   = led_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter with HOLD_CYCLES=4, HB_BIT=0.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_led_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] req = 3'b000;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic [7:0] data2 = 8'h00;
    logic [2:0] grant;
    logic [7:0] led;
    logic       busy;

    int checks = 0;
    int failures = 0;

    led_arbiter #(
        .HOLD_CYCLES(4),
        .HB_BIT     (0)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .req    (req),
        .data0  (data0),
        .data1  (data1),
        .data2  (data2),
        .grant  (grant),
        .led    (led),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Two reset edges, released on a falling edge.
    task automatic do_reset;
        @(negedge clk);
        reset_n = 1'b0;
        req     = 3'b000;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Reset values, then 300 idle cycles of heartbeat on the LEDs.
    task automatic test_reset;
        logic [7:0] e;
        @(negedge clk);
        reset_n = 1'b0;
        req     = 3'b000;
        @(negedge clk);
        checks++;
        if ({grant, busy, led} !== {3'b000, 1'b0, 8'hFF}) begin
            failures++;
            $display("FAIL reset_state got grant=%b busy=%b led=%h exp grant=000 busy=0 led=ff",
                     grant, busy, led);
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            // After k edges hb=k; led shows the previous hb, inverted.
            e = ~8'(k - 1);
            checks++;
            if ({grant, busy, led} !== {3'b000, 1'b0, e}) begin
                failures++;
                $display("FAIL idle_heartbeat cyc=%0d got grant=%b busy=%b led=%h exp grant=000 busy=0 led=%h",
                         k, grant, busy, led, e);
            end
        end
    endtask

    // Requester 1 holds for 10 cycles, then releases through one GAP cycle.
    task automatic test_single;
        do_reset();
        @(negedge clk);
        data1 = 8'hA5;
        req   = 3'b010;
        @(negedge clk);
        checks++;
        if ({grant, busy} !== {3'b010, 1'b1}) begin
            failures++;
            $display("FAIL single_grant got grant=%b busy=%b exp 010 1", grant, busy);
        end
        @(negedge clk);
        checks++;
        if ({grant, led} !== {3'b010, 8'h5A}) begin
            failures++;
            $display("FAIL single_led got grant=%b led=%h exp 010 5a", grant, led);
        end
        for (int i = 3; i <= 10; i++) begin
            @(negedge clk);
            checks++;
            if ({grant, led} !== {3'b010, 8'h5A}) begin
                failures++;
                $display("FAIL single_hold cyc=%0d got grant=%b led=%h exp 010 5a", i, grant, led);
            end
        end
        req = 3'b000;
        @(negedge clk);
        checks++;
        if ({grant, busy, led} !== {3'b000, 1'b1, 8'h5A}) begin
            failures++;
            $display("FAIL single_gap got grant=%b busy=%b led=%h exp 000 1 5a", grant, busy, led);
        end
        @(negedge clk);
        checks++;
        if ({grant, busy, led} !== {3'b000, 1'b0, 8'h5A}) begin
            failures++;
            $display("FAIL single_idle got grant=%b busy=%b led=%h exp 000 0 5a", grant, busy, led);
        end
    endtask

    // One-cycle pulse on req[2] still earns exactly four OWN cycles.
    task automatic test_pulse;
        do_reset();
        @(negedge clk);
        data2 = 8'h0F;
        req   = 3'b100;
        @(negedge clk);
        checks++;
        if ({grant, busy} !== {3'b100, 1'b1}) begin
            failures++;
            $display("FAIL pulse_grant got grant=%b busy=%b exp 100 1", grant, busy);
        end
        req = 3'b000;
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if ({grant, led} !== {3'b100, 8'hF0}) begin
                failures++;
                $display("FAIL pulse_own cyc=%0d got grant=%b led=%h exp 100 f0", i, grant, led);
            end
        end
        @(negedge clk);
        checks++;
        if ({grant, busy, led} !== {3'b000, 1'b1, 8'hF0}) begin
            failures++;
            $display("FAIL pulse_gap got grant=%b busy=%b led=%h exp 000 1 f0", grant, busy, led);
        end
        @(negedge clk);
        checks++;
        if ({grant, busy} !== {3'b000, 1'b0}) begin
            failures++;
            $display("FAIL pulse_idle got grant=%b busy=%b exp 000 0", grant, busy);
        end
    endtask

    // All three request continuously: 4 OWN cycles then 1 GAP, repeating.
    task automatic test_all_req;
        int pos;
        int own;
        logic [2:0] e;
        do_reset();
        @(negedge clk);
        req = 3'b111;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            pos = (i - 1) % 5;
`ifdef LED_ARB_RR_EN
            own = ((i - 1) / 5) % 3;
`else
            own = 0;
`endif
            e = (pos < 4) ? (3'b001 << own) : 3'b000;
            checks++;
            if (grant !== e) begin
                failures++;
                $display("FAIL all_req cyc=%0d got grant=%b exp %b", i, grant, e);
            end
        end
        req = 3'b000;
    endtask

    // A newcomer waits for hold expiry; the old owner then re-competes.
    task automatic test_handoff;
        logic [2:0] e;
        do_reset();
        @(negedge clk);
        data1 = 8'h11;
        data2 = 8'h22;
        req   = 3'b010;
        @(negedge clk);
        checks++;
        if (grant !== 3'b010) begin
            failures++;
            $display("FAIL handoff_grant got grant=%b exp 010", grant);
        end
        req = 3'b110;
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if ({grant, led} !== {3'b010, 8'hEE}) begin
                failures++;
                $display("FAIL handoff_nopreempt cyc=%0d got grant=%b led=%h exp 010 ee", i, grant, led);
            end
        end
        @(negedge clk);
        checks++;
        if ({grant, busy} !== {3'b000, 1'b1}) begin
            failures++;
            $display("FAIL handoff_gap got grant=%b busy=%b exp 000 1", grant, busy);
        end
        @(negedge clk);
`ifdef LED_ARB_RR_EN
        e = 3'b100;
`else
        e = 3'b010;
`endif
        checks++;
        if (grant !== e) begin
            failures++;
            $display("FAIL handoff_regrant got grant=%b exp %b", grant, e);
        end
        req = 3'b000;
    endtask

    // Reset in the third OWN cycle drops the grant with no GAP.
    task automatic test_reset_mid_own;
        do_reset();
        @(negedge clk);
        data0 = 8'h3C;
        req   = 3'b001;
        repeat (2) @(negedge clk);
        @(negedge clk);
        checks++;
        if ({grant, led} !== {3'b001, 8'hC3}) begin
            failures++;
            $display("FAIL midown_before got grant=%b led=%h exp 001 c3", grant, led);
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({grant, busy, led} !== {3'b000, 1'b0, 8'hFF}) begin
            failures++;
            $display("FAIL midown_reset got grant=%b busy=%b led=%h exp 000 0 ff", grant, busy, led);
        end
        @(negedge clk);
        checks++;
        if ({grant, busy} !== {3'b000, 1'b0}) begin
            failures++;
            $display("FAIL midown_held got grant=%b busy=%b exp 000 0", grant, busy);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({grant, busy} !== {3'b001, 1'b1}) begin
            failures++;
            $display("FAIL midown_regrant got grant=%b busy=%b exp 001 1", grant, busy);
        end
        req = 3'b000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_pulse();
        test_all_req();
        test_handoff();
        test_reset_mid_own();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
